// File: rtl/vga_bounce_renderer_if.sv
// Pixel-stage bundle: timing-generator inputs plus run control in, registered RGB and delayed syncs out.
interface vga_bounce_renderer_if #(
   parameter int CW = 4
);
   logic          draw;
   logic          hs;
   logic          vs;
   logic [9:0]    x;
   logic [8:0]    y;
   logic          run;
   logic [CW-1:0] r;
   logic [CW-1:0] g;
   logic [CW-1:0] b;
   logic          hs_o;
   logic          vs_o;

   modport master (
      output draw, hs, vs, x, y, run,
      input  r, g, b, hs_o, vs_o
   );

   modport slave (
      input  draw, hs, vs, x, y, run,
      output r, g, b, hs_o, vs_o
   );
endinterface

// File: rtl/vga_bounce_renderer.sv
// Checkerboard background with a bouncing solid box; the box position only
// advances on the falling edge of vsync, so every frame shows one position.
module vga_bounce_renderer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int BOX        = 32,
   parameter int STEP       = 2,
   parameter int TILE_SHIFT = 5,
   parameter int CW         = 4,
   parameter int INIT_X     = 0,
   parameter int INIT_Y     = 0
) (
   input logic                  clk,
   input logic                  rst,
   vga_bounce_renderer_if.slave vga
);
   localparam logic [10:0] X_MAX  = 11'(H_RES - BOX);
   localparam logic [10:0] Y_MAX  = 11'(V_RES - BOX);
   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [10:0] BOX11  = 11'(BOX);

   logic        vs_q;
   logic        tick;
   logic [10:0] box_x, box_y;
   logic        dir_x, dir_y;
   logic [10:0] box_x_nxt, box_y_nxt;
   logic        dir_x_nxt, dir_y_nxt;
   logic [10:0] px, py;
   logic        in_box;
   logic        tile;

   assign tick = vs_q & ~vga.vs & vga.run;

   // 11-bit sums keep box_x+STEP and box_x+BOX from wrapping near the edges
   always_comb begin
      box_x_nxt = box_x;
      dir_x_nxt = dir_x;
      box_y_nxt = box_y;
      dir_y_nxt = dir_y;
      if (dir_x) begin
         if (box_x + STEP11 >= X_MAX) begin
            box_x_nxt = X_MAX;
            dir_x_nxt = 1'b0;
         end else begin
            box_x_nxt = box_x + STEP11;
         end
      end else begin
         if (box_x <= STEP11) begin
            box_x_nxt = '0;
            dir_x_nxt = 1'b1;
         end else begin
            box_x_nxt = box_x - STEP11;
         end
      end
      if (dir_y) begin
         if (box_y + STEP11 >= Y_MAX) begin
            box_y_nxt = Y_MAX;
            dir_y_nxt = 1'b0;
         end else begin
            box_y_nxt = box_y + STEP11;
         end
      end else begin
         if (box_y <= STEP11) begin
            box_y_nxt = '0;
            dir_y_nxt = 1'b1;
         end else begin
            box_y_nxt = box_y - STEP11;
         end
      end
   end

   assign px     = {1'b0, vga.x};
   assign py     = {2'b00, vga.y};
   assign in_box = (px >= box_x) && (px < box_x + BOX11) &&
                   (py >= box_y) && (py < box_y + BOX11);
   assign tile   = vga.x[TILE_SHIFT] ^ vga.y[TILE_SHIFT];

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q  <= 1'b1;
         box_x <= 11'(INIT_X);
         box_y <= 11'(INIT_Y);
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else begin
         vs_q <= vga.vs;
         if (tick) begin
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
         end
      end
   end

   // pixel colour uses the box position held before this edge
   always_ff @(posedge clk) begin
      if (rst) begin
         vga.r    <= '0;
         vga.g    <= '0;
         vga.b    <= '0;
         vga.hs_o <= 1'b1;
         vga.vs_o <= 1'b1;
      end else begin
         vga.hs_o <= vga.hs;
         vga.vs_o <= vga.vs;
         if (!vga.draw) begin
            vga.r <= '0;
            vga.g <= '0;
            vga.b <= '0;
         end else if (in_box) begin
            vga.r <= '1;
            vga.g <= '1;
            vga.b <= '1;
         end else if (tile) begin
            vga.r <= '0;
            vga.g <= '0;
            vga.b <= {1'b0, {(CW-1){1'b1}}};
         end else begin
            vga.r <= '0;
            vga.g <= '0;
            vga.b <= '0;
         end
      end
   end
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Scoreboarded directed bench for vga_bounce_renderer: each driven cycle queues
// its expected outputs, and a monitor compares one cycle later.
module tb_vga_bounce_renderer;
   logic clk = 1'b0;
   logic rst;
   logic rst_v = 1'b1;
   logic run_v = 1'b0;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t  q_exp[$];
   string q_name[$];

   vga_bounce_renderer_if #(.CW(4)) vif ();

   vga_bounce_renderer #(
      .H_RES(640), .V_RES(480), .BOX(32), .STEP(2), .TILE_SHIFT(5),
      .CW(4), .INIT_X(0), .INIT_Y(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vga(vif.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] bg_blue(input int xi, input int yi);
      return ((((xi >> 5) ^ (yi >> 5)) & 1) != 0) ? 4'h7 : 4'h0;
   endfunction

   task automatic cyc(input logic d, input int xi, input int yi, input logic h,
                      input logic v, input logic [3:0] er, input logic [3:0] eg,
                      input logic [3:0] eb, input string nm);
      exp_t e;
      @(negedge clk);
      rst      = rst_v;
      vif.run  = run_v;
      vif.draw = d;
      vif.x    = 10'(xi);
      vif.y    = 9'(yi);
      vif.hs   = h;
      vif.vs   = v;
      e.r  = rst_v ? 4'h0 : er;
      e.g  = rst_v ? 4'h0 : eg;
      e.b  = rst_v ? 4'h0 : eb;
      e.hs = rst_v ? 1'b1 : h;
      e.vs = rst_v ? 1'b1 : v;
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   task automatic pix(input int xi, input int yi, input logic white, input string nm);
      if (white) cyc(1'b1, xi, yi, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, nm);
      else       cyc(1'b1, xi, yi, 1'b1, 1'b1, 4'h0, 4'h0, bg_blue(xi, yi), nm);
   endtask

   task automatic probe(input int bx, input int by, input string nm);
      pix(bx, by, 1'b1, {nm, "_tl"});
      pix(bx + 31, by + 31, 1'b1, {nm, "_br"});
      if (bx > 0)         pix(bx - 1, by, 1'b0, {nm, "_left"});
      if (bx + 32 < 640)  pix(bx + 32, by, 1'b0, {nm, "_right"});
      if (by > 0)         pix(bx, by - 1, 1'b0, {nm, "_above"});
      if (by + 32 < 480)  pix(bx, by + 32, 1'b0, {nm, "_below"});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, "tick_lo");
         cyc(1'b0, 0, 0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "tick_hi");
      end
   endtask

   // monitor: every output cycle is paired with the oldest queued expectation
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            tests++;
            if ({vif.r, vif.g, vif.b, vif.hs_o, vif.vs_o} !== e) begin
               fails++;
               $display("FAIL %s: got r=%h g=%h b=%h hs_o=%b vs_o=%b, expected r=%h g=%h b=%h hs_o=%b vs_o=%b",
                        nm, vif.r, vif.g, vif.b, vif.hs_o, vif.vs_o, e.r, e.g, e.b, e.hs, e.vs);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      vif.run  = 1'b0;
      vif.draw = 1'b0;
      vif.x    = '0;
      vif.y    = '0;
      vif.hs   = 1'b1;
      vif.vs   = 1'b1;

      rst_v = 1'b1;
      repeat (3) cyc(1'b0, 0, 0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "reset");
      rst_v = 1'b0;

      cyc(1'b1, 5, 5, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF, "px_5_5_box");
      cyc(1'b1, 40, 5, 1'b1, 1'b1, 4'h0, 4'h0, 4'h7, "px_40_5_blue");
      cyc(1'b1, 40, 40, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "px_40_40_black");
      cyc(1'b0, 5, 5, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "px_nodraw");
      probe(0, 0, "init_box");

      cyc(1'b0, 0, 0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, "align_hs0");
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, "align_vs0");
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, "align_both0");
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "align_both1");
      probe(0, 0, "frozen_after_align");

      run_v = 1'b1;
      ticks(3);
      probe(6, 6, "move3");

      run_v = 1'b0;
      ticks(2);
      probe(6, 6, "run0");

      // vs goes low while run=0, then held low and raised with run=1: no tick
      cyc(1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, "vs_fall_run0");
      run_v = 1'b1;
      repeat (3) cyc(1'b0, 0, 0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, "vs_held_low");
      cyc(1'b0, 0, 0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, "vs_rise");
      probe(6, 6, "no_move_rise");

      ticks(221);
      probe(448, 448, "bottom_edge");
      ticks(1);
      probe(450, 446, "bottom_bounce");
      ticks(78);
      probe(606, 290, "near_right");
      ticks(1);
      probe(608, 288, "right_edge");
      ticks(1);
      probe(606, 286, "right_bounce");
      ticks(143);
      probe(320, 0, "top_edge");
      ticks(1);
      probe(318, 2, "top_bounce");
      ticks(158);
      probe(2, 318, "near_left");
      ticks(1);
      probe(0, 320, "left_edge");
      ticks(1);
      probe(2, 322, "left_bounce");

      rst_v = 1'b1;
      cyc(1'b1, 10, 330, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, "rst_mid_draw");
      rst_v = 1'b0;
      probe(0, 0, "after_mid_reset");
      ticks(1);
      probe(2, 2, "dir_after_reset");

      repeat (3) @(negedge clk);
      tests++;
      if (q_exp.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
